// File: rtl/datamover_rd_multi.sv
// ---------------------------------------------------------------------------
// datamover_rd_multi
//
// Splits one read request (start address + byte length) into a sequence of
// MM2S datamover commands. No command is larger than MAX_BTT bytes, and no
// command crosses a 4 KB address boundary. The returned read stream is
// forwarded combinationally to a downstream AXI-Stream port. TLAST is only
// passed through on the final chunk, so downstream sees one packet per request.
//
// Optional feature: define DATAMOVER_RD_STS_EN to add the datamover status
// port and an STS state. In that state, the status of each chunk is checked
// against the tag that was issued for it.
//
// Ports
//   clk, rst                 clock; synchronous active-high reset
//   i_start                  request; acted on at its rising edge, in IDLE only
//   i_length, i_start_addr   total bytes and start byte address, latched on accept
//   o_busy                   high in every state except IDLE
//   o_done                   one-cycle pulse at the end of a request
//   o_err                    sticky error (byte count, status); cleared on accept
//   o_mm2s_rd_cmd_*          command stream to the datamover (CMD_W bits)
//   i_mm2s_rd_* / o_..tready read data stream from the datamover
//   o_m_* / i_m_tready       downstream data stream
//   i_mm2s_sts_* / o_..tready status stream (DATAMOVER_RD_STS_EN only)
// ---------------------------------------------------------------------------
module datamover_rd_multi #(
  parameter  int ADDR_W  = 32,
  parameter  int LEN_W   = 24,
  parameter  int MAX_BTT = 4096,
  parameter  int DATA_W  = 64,
  localparam int CMD_W   = ADDR_W + 40,
  localparam int KEEP_W  = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [LEN_W-1:0]  i_length,
  input  logic [ADDR_W-1:0] i_start_addr,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [CMD_W-1:0]  o_mm2s_rd_cmd_tdata,
  output logic              o_mm2s_rd_cmd_tvalid,
  input  logic              i_mm2s_rd_cmd_tready,
  input  logic [DATA_W-1:0] i_mm2s_rd_tdata,
  input  logic [KEEP_W-1:0] i_mm2s_rd_tkeep,
  input  logic              i_mm2s_rd_tvalid,
  input  logic              i_mm2s_rd_tlast,
  output logic              o_mm2s_rd_tready,
  output logic [DATA_W-1:0] o_m_tdata,
  output logic [KEEP_W-1:0] o_m_tkeep,
  output logic              o_m_tvalid,
  output logic              o_m_tlast,
  input  logic              i_m_tready
`ifdef DATAMOVER_RD_STS_EN
  ,
  input  logic [7:0]        i_mm2s_sts_tdata,
  input  logic              i_mm2s_sts_tvalid,
  output logic              o_mm2s_sts_tready
`endif
);

  // Counter width: it must hold both a full remaining length and a 4096-byte chunk.
  localparam int CNT_W = (LEN_W > 13) ? LEN_W : 13;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
`ifdef DATAMOVER_RD_STS_EN
    ST_STS,
`endif
    ST_DONE
  } state_t;

  state_t              state_q, state_d;
  logic                start_q, start_d;
  logic                start_prev_q, start_prev_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic [12:0]         chunk_q, chunk_d;
  logic [3:0]          tag_q, tag_d;
  logic [CNT_W-1:0]    byte_cnt_q, byte_cnt_d;
  logic                err_q, err_d;
`ifdef DATAMOVER_RD_STS_EN
  logic [3:0]          issued_tag_q, issued_tag_d;
`endif

  logic                start_edge;
  logic                beat_fire;
  logic                last_chunk;
  logic [12:0]         to_boundary;
  logic [12:0]         lim;
  logic [12:0]         chunk_c;
  logic [CNT_W-1:0]    rem_ext;
  logic [CNT_W-1:0]    beat_bytes;
  logic [CNT_W-1:0]    chunk_total;

  // The edge is seen on the registered copy, so a request is accepted one
  // cycle after i_start is first sampled high.
  assign start_edge = start_q & ~start_prev_q;
  assign beat_fire  = (state_q == ST_DATA) && i_mm2s_rd_tvalid && i_m_tready;
  assign last_chunk = (state_q == ST_DATA) && (rem_q == '0);

  // Chunk size = min(remaining, MAX_BTT, bytes left before the next 4 KB boundary).
  always_comb begin
    to_boundary = 13'd4096 - {1'b0, addr_q[11:0]};
    lim         = (to_boundary < 13'(MAX_BTT)) ? to_boundary : 13'(MAX_BTT);
    rem_ext     = CNT_W'(rem_q);
    chunk_c     = (rem_ext < CNT_W'(lim)) ? rem_ext[12:0] : lim;
  end

  // Bytes carried by the current beat.
  always_comb begin
    beat_bytes = '0;
    // NOTE: blocking assignment is correct in combinational logic. Each loop
    // iteration has to see the sum from the previous iteration.
    for (int i = 0; i < KEEP_W; i++) begin
      beat_bytes = beat_bytes + CNT_W'(i_mm2s_rd_tkeep[i]);
    end
  end

  assign chunk_total = byte_cnt_q + beat_bytes;

  always_comb begin
    // NOTE: every _d starts with its hold value, so no branch can leave a
    // signal unassigned and infer a latch.
    state_d      = state_q;
    start_d      = i_start;
    start_prev_d = start_q;
    addr_d       = addr_q;
    rem_d        = rem_q;
    chunk_d      = chunk_q;
    tag_d        = tag_q;
    byte_cnt_d   = byte_cnt_q;
    err_d        = err_q;
`ifdef DATAMOVER_RD_STS_EN
    issued_tag_d = issued_tag_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          addr_d     = i_start_addr;
          rem_d      = i_length;
          tag_d      = 4'd0;
          byte_cnt_d = '0;
          err_d      = 1'b0;
          state_d    = (i_length == '0) ? ST_DONE : ST_CMD;
        end
      end

      ST_CMD: begin
        if (i_mm2s_rd_cmd_tready) begin
          addr_d     = addr_q + ADDR_W'(chunk_c);
          rem_d      = rem_q - LEN_W'(chunk_c);
          chunk_d    = chunk_c;
          tag_d      = tag_q + 4'd1;
          byte_cnt_d = '0;
`ifdef DATAMOVER_RD_STS_EN
          issued_tag_d = tag_q;
`endif
          state_d    = ST_DATA;
        end
      end

      ST_DATA: begin
        if (beat_fire) begin
          byte_cnt_d = chunk_total;
          if (i_mm2s_rd_tlast) begin
            byte_cnt_d = '0;
            if (chunk_total != CNT_W'(chunk_q)) err_d = 1'b1;
`ifdef DATAMOVER_RD_STS_EN
            state_d = ST_STS;
`else
            state_d = (rem_q != '0) ? ST_CMD : ST_DONE;
`endif
          end
        end
      end

`ifdef DATAMOVER_RD_STS_EN
      ST_STS: begin
        if (i_mm2s_sts_tvalid) begin
          // Status layout: bit7 OKAY, bits6:4 error flags, bits3:0 tag.
          if (!i_mm2s_sts_tdata[7] || (|i_mm2s_sts_tdata[6:4]) ||
              (i_mm2s_sts_tdata[3:0] != issued_tag_q)) begin
            err_d = 1'b1;
          end
          state_d = (rem_q != '0) ? ST_CMD : ST_DONE;
        end
      end
`endif

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments, so all flops
  // update together at the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      start_q      <= 1'b0;
      start_prev_q <= 1'b0;
      addr_q       <= '0;
      rem_q        <= '0;
      chunk_q      <= '0;
      tag_q        <= 4'd0;
      byte_cnt_q   <= '0;
      err_q        <= 1'b0;
`ifdef DATAMOVER_RD_STS_EN
      issued_tag_q <= 4'd0;
`endif
    end else begin
      state_q      <= state_d;
      start_q      <= start_d;
      start_prev_q <= start_prev_d;
      addr_q       <= addr_d;
      rem_q        <= rem_d;
      chunk_q      <= chunk_d;
      tag_q        <= tag_d;
      byte_cnt_q   <= byte_cnt_d;
      err_q        <= err_d;
`ifdef DATAMOVER_RD_STS_EN
      issued_tag_q <= issued_tag_d;
`endif
    end
  end

  assign o_busy               = (state_q != ST_IDLE);
  assign o_done               = (state_q == ST_DONE);
  assign o_err                = err_q;
  assign o_mm2s_rd_cmd_tvalid = (state_q == ST_CMD);
  // Fields: reserved, tag, address, DRR=0, EOF=1, DSA=0, INCR=1, BTT.
  // All inputs to the command are held in CMD, so it stays stable while stalled.
  assign o_mm2s_rd_cmd_tdata  = (state_q == ST_CMD)
                              ? {4'd0, tag_q, addr_q, 1'b0, 1'b1, 6'd0, 1'b1, 10'd0, chunk_c}
                              : '0;

  assign o_m_tdata        = i_mm2s_rd_tdata;
  assign o_m_tkeep        = i_mm2s_rd_tkeep;
  assign o_m_tvalid       = i_mm2s_rd_tvalid;
  assign o_m_tlast        = i_mm2s_rd_tlast & last_chunk;
  assign o_mm2s_rd_tready = i_m_tready;

`ifdef DATAMOVER_RD_STS_EN
  assign o_mm2s_sts_tready = (state_q == ST_STS);
`endif

endmodule

// File: tb/tb_datamover_rd_multi.sv
// ---------------------------------------------------------------------------
// tb_datamover_rd_multi
//
// Directed and randomized requests for datamover_rd_multi. The expected list
// of commands for each request comes from the chunking rule, applied with
// plain arithmetic. The bench then acts as the datamover and the downstream
// sink, and compares commands, the forwarded stream, TLAST placement,
// done/busy/err behaviour, and the reset behaviour.
// ---------------------------------------------------------------------------
module tb_datamover_rd_multi;

  localparam int ADDR_W  = 32;
  localparam int LEN_W   = 24;
  localparam int MAX_BTT = 4096;
  localparam int DATA_W  = 64;
  localparam int CMD_W   = ADDR_W + 40;
  localparam int KEEP_W  = DATA_W / 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_start = 1'b0;
  logic [LEN_W-1:0]  i_length = '0;
  logic [ADDR_W-1:0] i_start_addr = '0;
  logic              o_busy, o_done, o_err;
  logic [CMD_W-1:0]  o_mm2s_rd_cmd_tdata;
  logic              o_mm2s_rd_cmd_tvalid;
  logic              i_mm2s_rd_cmd_tready = 1'b0;
  logic [DATA_W-1:0] i_mm2s_rd_tdata = '0;
  logic [KEEP_W-1:0] i_mm2s_rd_tkeep = '0;
  logic              i_mm2s_rd_tvalid = 1'b0;
  logic              i_mm2s_rd_tlast = 1'b0;
  logic              o_mm2s_rd_tready;
  logic [DATA_W-1:0] o_m_tdata;
  logic [KEEP_W-1:0] o_m_tkeep;
  logic              o_m_tvalid, o_m_tlast;
  logic              i_m_tready = 1'b1;
`ifdef DATAMOVER_RD_STS_EN
  logic [7:0]        i_mm2s_sts_tdata = 8'h80;
  logic              i_mm2s_sts_tvalid = 1'b1;
  logic              o_mm2s_sts_tready;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  datamover_rd_multi #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W),
    .MAX_BTT(MAX_BTT),
    .DATA_W (DATA_W)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .i_start             (i_start),
    .i_length            (i_length),
    .i_start_addr        (i_start_addr),
    .o_busy              (o_busy),
    .o_done              (o_done),
    .o_err               (o_err),
    .o_mm2s_rd_cmd_tdata (o_mm2s_rd_cmd_tdata),
    .o_mm2s_rd_cmd_tvalid(o_mm2s_rd_cmd_tvalid),
    .i_mm2s_rd_cmd_tready(i_mm2s_rd_cmd_tready),
    .i_mm2s_rd_tdata     (i_mm2s_rd_tdata),
    .i_mm2s_rd_tkeep     (i_mm2s_rd_tkeep),
    .i_mm2s_rd_tvalid    (i_mm2s_rd_tvalid),
    .i_mm2s_rd_tlast     (i_mm2s_rd_tlast),
    .o_mm2s_rd_tready    (o_mm2s_rd_tready),
    .o_m_tdata           (o_m_tdata),
    .o_m_tkeep           (o_m_tkeep),
    .o_m_tvalid          (o_m_tvalid),
    .o_m_tlast           (o_m_tlast),
    .i_m_tready          (i_m_tready)
`ifdef DATAMOVER_RD_STS_EN
    ,
    .i_mm2s_sts_tdata    (i_mm2s_sts_tdata),
    .i_mm2s_sts_tvalid   (i_mm2s_sts_tvalid),
    .o_mm2s_sts_tready   (o_mm2s_sts_tready)
`endif
  );

  task automatic check(input string tag, input logic [CMD_W-1:0] obs, input logic [CMD_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Raise i_start and hold the request inputs over the accept edge. Then
  // drop i_start and scramble the inputs, which the DUT must ignore.
  task automatic pulse_start(input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len);
    @(negedge clk);
    i_start_addr = addr;
    i_length     = len;
    i_start      = 1'b1;
    @(negedge clk);
    check("accept_latency_busy", o_busy, 0);
    check("accept_latency_cmd", o_mm2s_rd_cmd_tvalid, 0);
    @(negedge clk);
    i_start      = 1'b0;
    i_start_addr = $urandom;
    i_length     = LEN_W'($urandom);
  endtask

  // Wait for a command, stall it for `stall` cycles, then accept it.
  task automatic do_cmd(input logic [CMD_W-1:0] exp, input int stall);
    int n = 0;
    while (o_mm2s_rd_cmd_tvalid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("cmd_tvalid", o_mm2s_rd_cmd_tvalid, 1);
    for (int s = 0; s < stall; s++) begin
      check("cmd_stall_stable", o_mm2s_rd_cmd_tdata, exp);
      @(negedge clk);
    end
    i_mm2s_rd_cmd_tready = 1'b1;
    #1;
    check("cmd_tdata", o_mm2s_rd_cmd_tdata, exp);
    @(negedge clk);
    i_mm2s_rd_cmd_tready = 1'b0;
    check("cmd_drop", o_mm2s_rd_cmd_tvalid, 0);
  endtask

  // Send one chunk of read data. Idle gaps and downstream back-pressure are
  // inserted at random. `bad` drops a byte from the last beat.
  task automatic do_chunk(input int c, input bit is_final, input bit bad);
    int nb;
    int rb;
    nb = (c + 7) / 8;
    for (int b = 0; b < nb; b++) begin
      bit               lst;
      logic [KEEP_W-1:0] k;
      logic [DATA_W-1:0] d;
      lst = (b == nb - 1);
      rb  = lst ? c - 8 * (nb - 1) : 8;
      k   = KEEP_W'((16'd1 << rb) - 16'd1);
      if (bad && lst) k = k >> 1;
      d   = {$urandom, $urandom};
      if ($urandom_range(0, 4) == 0) begin
        i_mm2s_rd_tvalid = 1'b0;
        i_mm2s_rd_tkeep  = '1;
        i_m_tready       = 1'b1;
        @(negedge clk);
      end
      i_mm2s_rd_tdata  = d;
      i_mm2s_rd_tkeep  = k;
      i_mm2s_rd_tlast  = lst;
      i_mm2s_rd_tvalid = 1'b1;
      if ($urandom_range(0, 3) == 0) begin
        i_m_tready = 1'b0;
        #1;
        check("rd_tready_backpressure", o_mm2s_rd_tready, 0);
        @(negedge clk);
      end
      i_m_tready = 1'b1;
      #1;
      check("m_tlast", o_m_tlast, is_final && lst);
      if (b == 0 || lst) begin
        check("m_tdata", o_m_tdata, d);
        check("m_tkeep", o_m_tkeep, k);
        check("m_tvalid", o_m_tvalid, 1);
      end
      @(negedge clk);
    end
    i_mm2s_rd_tvalid = 1'b0;
    i_mm2s_rd_tlast  = 1'b0;
  endtask

  task automatic wait_done(input bit exp_err);
    int n = 0;
    while (o_done !== 1'b1 && n < 32) begin
      @(negedge clk);
      n++;
    end
    check("done_pulse", o_done, 1);
    check("done_err", o_err, exp_err);
    @(negedge clk);
    check("done_single", o_done, 0);
    check("idle_busy", o_busy, 0);
    check("err_sticky", o_err, exp_err);
  endtask

  // Reference: the expected chunk list is built from min(remaining, MAX_BTT,
  // distance to the next 4 KB boundary). Tags count up from 0.
  task automatic run_transfer(input logic [ADDR_W-1:0] addr, input int len, input int cstall,
                              input bit poke, input int bad_chunk, input bit bad_sts);
    int                chunks[$];
    logic [ADDR_W-1:0] addrs[$];
    logic [ADDR_W-1:0] a;
    int                r;
    int                c;
    bit                exp_err;
    a = addr;
    r = len;
    exp_err = 1'b0;
    while (r > 0) begin
      c = r;
      if (c > MAX_BTT) c = MAX_BTT;
      if (c > 4096 - int'(a[11:0])) c = 4096 - int'(a[11:0]);
      chunks.push_back(c);
      addrs.push_back(a);
      a = a + ADDR_W'(c);
      r = r - c;
    end

    pulse_start(addr, len[LEN_W-1:0]);
    if (len == 0) begin
      check("zero_done", o_done, 1);
      check("zero_busy", o_busy, 1);
      check("zero_no_cmd", o_mm2s_rd_cmd_tvalid, 0);
      check("zero_err", o_err, 0);
      @(negedge clk);
      check("zero_done_single", o_done, 0);
      check("zero_busy_one_cycle", o_busy, 0);
      return;
    end

    foreach (chunks[i]) begin
      logic [3:0] tg;
      tg = 4'(i);
      do_cmd({4'h0, tg, addrs[i], 8'h40, 1'b1, 23'(chunks[i])}, cstall);
      if (poke && i == 0) i_start = 1'b1;
`ifdef DATAMOVER_RD_STS_EN
      i_mm2s_sts_tdata = bad_sts ? 8'h00 : {4'h8, tg};
      if (bad_sts) exp_err = 1'b1;
`endif
      do_chunk(chunks[i], i == chunks.size() - 1, i == bad_chunk);
      if (i == bad_chunk) exp_err = 1'b1;
      i_start = 1'b0;
    end
    wait_done(exp_err);
    if (poke) begin
      repeat (4) begin
        @(negedge clk);
        check("second_edge_ignored", o_busy, 0);
      end
    end
  endtask

  initial begin
    int                n_done;
    logic [ADDR_W-1:0] ra;
    int                rl;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_err", o_err, 0);
    check("rst_cmd_tvalid", o_mm2s_rd_cmd_tvalid, 0);
    check("rst_cmd_tdata", o_mm2s_rd_cmd_tdata, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Directed cases
    run_transfer(32'h0000_1000, 256, 0, 1'b0, -1, 1'b0);
    run_transfer(32'h0000_0F00, 32'h300, 1, 1'b0, -1, 1'b0);
    run_transfer(32'h0000_0000, 10000, 0, 1'b0, -1, 1'b0);
    run_transfer(32'h0000_1234, 0, 0, 1'b0, -1, 1'b0);
    run_transfer(32'h0000_3000, 1000, 5, 1'b1, -1, 1'b0);
    run_transfer(32'h0000_5008, 300, 0, 1'b0, 0, 1'b0);
    run_transfer(32'h0000_6000, 17, 0, 1'b0, -1, 1'b0);
    run_transfer(32'h0000_6FF9, 20, 2, 1'b0, 1, 1'b0);
`ifdef DATAMOVER_RD_STS_EN
    run_transfer(32'h0000_7000, 64, 0, 1'b0, -1, 1'b1);
    i_mm2s_sts_tdata = 8'h80;
`endif

    // Reset in the middle of DATA: go back to IDLE, with no done pulse
    pulse_start(32'h0000_2000, 64);
    do_cmd({4'h0, 4'h0, 32'h0000_2000, 8'h40, 1'b1, 23'd64}, 0);
    i_mm2s_rd_tkeep  = '1;
    i_mm2s_rd_tvalid = 1'b1;
    i_m_tready       = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    i_mm2s_rd_tvalid = 1'b0;
    check("midrst_busy", o_busy, 0);
    check("midrst_done", o_done, 0);
    check("midrst_cmd_tvalid", o_mm2s_rd_cmd_tvalid, 0);
    check("midrst_cmd_tdata", o_mm2s_rd_cmd_tdata, 0);
    n_done = 0;
    repeat (10) begin
      @(negedge clk);
      if (o_done === 1'b1) n_done++;
    end
    check("midrst_no_done", n_done, 0);
    check("midrst_idle", o_busy, 0);

    // Randomized requests
    for (int t = 0; t < 14; t++) begin
      ra = $urandom & 32'h0FFF_FFFF;
      if ($urandom_range(0, 1) == 1) ra[11:0] = 12'hFFF - 12'($urandom_range(0, 64));
      rl = $urandom_range(0, 3000);
      run_transfer(ra, rl, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 4) == 0) ? 0 : -1, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog, so the bench always ends
  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/datamover_rd_multi.md
DATAMOVER_RD_MULTI -- requirements
Module: datamover_rd_multi

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width; command width CMD_W = ADDR_W+40.
REQ-002 SHALL have parameter LEN_W, default 24, total transfer-length width in bytes.
REQ-003 SHALL have parameter MAX_BTT, default 4096, maximum bytes per command; power of two, 8..4096.
REQ-004 SHALL have parameter DATA_W, default 64, stream width; KEEP_W = DATA_W/8.
REQ-005 SHALL have port clk, input, 1, sole clock.
REQ-006 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-007 SHALL have ports i_start (in, 1, rising-edge request), i_length (in, LEN_W, total bytes), i_start_addr (in, ADDR_W, start byte address).
REQ-008 SHALL have ports o_busy (out, 1), o_done (out, 1, one-cycle pulse), o_err (out, 1, sticky).
REQ-009 SHALL have ports o_mm2s_rd_cmd_tdata (out, CMD_W), o_mm2s_rd_cmd_tvalid (out, 1), i_mm2s_rd_cmd_tready (in, 1).
REQ-010 SHALL have ports i_mm2s_rd_tdata (in, DATA_W), i_mm2s_rd_tkeep (in, KEEP_W), i_mm2s_rd_tvalid, i_mm2s_rd_tlast (in, 1), o_mm2s_rd_tready (out, 1).
REQ-011 SHALL have ports o_m_tdata (out, DATA_W), o_m_tkeep (out, KEEP_W), o_m_tvalid, o_m_tlast (out, 1), i_m_tready (in, 1): downstream stream.

Function
REQ-012 SHALL register i_start and detect its rising edge; request accepted one cycle after the edge, only in IDLE; edges while busy ignored.
REQ-013 SHALL latch i_start_addr and i_length on acceptance; later input changes have no effect.
REQ-014 SHALL implement states IDLE, CMD, DATA, (STS when enabled), DONE; IDLE->CMD on accepted request with length>0; IDLE->DONE if length=0 (no command issued).
REQ-015 SHALL compute each chunk as min(remaining, MAX_BTT, 4096 - addr[11:0]); no command crosses a 4 KB boundary.
REQ-016 SHALL in CMD hold tvalid=1 and tdata stable until tready; CMD->DATA on tvalid&tready; then addr += chunk, remaining -= chunk, tag += 1 (4-bit wrap).
REQ-017 SHALL format command: [CMD_W-1:CMD_W-4]=0, [CMD_W-5:CMD_W-8]=tag, [ADDR_W+31:32]=addr, [31]=0, [30]=EOF=1, [29:24]=0, [23]=INCR=1, [22:0]=chunk bytes; tag starts at 0 per request.
REQ-018 SHALL connect stream combinationally: o_m_* = i_mm2s_rd_*, o_mm2s_rd_tready = i_m_tready; o_m_tlast = i_mm2s_rd_tlast only on final chunk, else 0.
REQ-019 SHALL count accepted bytes per chunk (popcount tkeep); on tlast beat, mismatch with chunk sets o_err.
REQ-020 SHALL in DATA advance on tlast&tvalid&tready: to CMD if remaining>0, else DONE.
REQ-021 SHALL in DONE assert o_done one cycle, return to IDLE next cycle.
REQ-022 SHALL drive o_busy=1 in every state except IDLE.
REQ-023 SHALL clear o_err on accepted request; o_err persists through DONE.

Reset
REQ-024 SHALL on rst force IDLE; o_busy, o_done, o_err, cmd tvalid, cmd tdata = 0; tag = 0; counters 0.
REQ-025 SHALL abort any in-flight transfer on mid-operation rst with no o_done; draining the datamover is the system's responsibility.

Configuration
REQ-026 SHALL, with DATAMOVER_RD_STS_EN defined, add ports i_mm2s_sts_tdata (in, 8), i_mm2s_sts_tvalid (in, 1), o_mm2s_sts_tready (out, 1 only in STS); DATA->STS on tlast; STS exits on status handshake; o_err set if bit7 (OKAY)=0, any of bits[6:4]=1, or bits[3:0] != issued tag.
REQ-027 SHALL, without DATAMOVER_RD_STS_EN, omit status ports and STS state; DATA transitions directly per REQ-020.

Verification
REQ-028 SHALL test addr 0x1000, len 256, tready=1: one command BTT=256, tag 0; 32 beats; o_m_tlast on beat 32; o_done once; o_err=0.
REQ-029 SHALL test addr 0x0F00, len 0x300: commands BTT 0x100 @0x0F00 tag 0, BTT 0x200 @0x1000 tag 1; o_m_tlast only at end.
REQ-030 SHALL test len 10000, MAX_BTT 4096, addr 0: BTTs 4096, 4096, 1808; tags 0,1,2; o_done after third tlast.
REQ-031 SHALL test len 0: no cmd tvalid, o_done two cycles after edge, o_busy high one cycle.
REQ-032 SHALL test cmd tready low 5 cycles, then second i_start edge during DATA: tdata stable while stalled, second edge ignored.
REQ-033 SHALL test (STS_EN) status 0x00 for tag 0: o_err=1, o_done still pulses; rst mid-DATA returns IDLE, no o_done.
